// File: rtl/cpu_pkg.sv
// Shared CPU types: memory access widths, load/store unit states and a width helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    BITS8  = 2'd0,
    BITS16 = 2'd1,
    BITS32 = 2'd2
  } MemWidth;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } LsuState;

  function automatic logic [2:0] width_bytes(MemWidth w);
    case (w)
      BITS8:   return 3'd1;
      BITS16:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of assembled little-endian load bytes to 32 bits.
module load_extend
  import cpu_pkg::*;
(
  input  logic [31:0] bytes_i,
  input  MemWidth     width_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = bytes_i;
    case (width_i)
      BITS8:   data_o = {{24{bytes_i[7]  & ~unsigned_i}}, bytes_i[7:0]};
      BITS16:  data_o = {{16{bytes_i[15] & ~unsigned_i}}, bytes_i[15:0]};
      default: data_o = bytes_i;
    endcase
  end

endmodule

// File: rtl/lsu_byte_serial.sv
// Load/store unit: serialises LB/LH/LW/LBU/LHU/SB/SH/SW onto an 8-bit
// little-endian Ram port and returns extended load data.
module lsu_byte_serial
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_width,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  LsuState           state_q;
  logic [1:0]        idx_q;
  logic              write_q;
  MemWidth           width_q;
  logic              unsigned_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       bytes_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [7:0]        mem_wdata_q;

  logic [1:0]  idx_d;
  logic [31:0] bytes_d;
  logic [31:0] ext_data;
  logic        last_byte;

  assign idx_d     = idx_q + 2'd1;
  assign last_byte = ({1'b0, idx_q} == (width_bytes(width_q) - 3'd1));

  // Current Ram byte merged in so the final byte reaches the extender
  // in the same cycle it is read.
  always_comb begin
    bytes_d = bytes_q;
    bytes_d[{idx_q, 3'b000} +: 8] = mem_rdata;
  end

  load_extend u_load_extend (
    .bytes_i    (bytes_d),
    .width_i    (width_q),
    .unsigned_i (unsigned_q),
    .data_o     (ext_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      write_q      <= 1'b0;
      width_q      <= BITS8;
      unsigned_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      bytes_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 8'd0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            width_q    <= MemWidth'(req_width);
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            idx_q      <= 2'd0;
            bytes_q    <= 32'd0;
            if (req_width == 2'd3) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q     <= XFER;
              mem_addr_q  <= req_addr;
              mem_we_q    <= req_write;
              mem_wdata_q <= req_wdata[7:0];
            end
          end
        end
        XFER: begin
          bytes_q <= bytes_d;
          idx_q   <= idx_d;
          if (last_byte) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            mem_we_q     <= 1'b0;
            if (!write_q) resp_rdata_q <= ext_data;
          end else begin
            mem_addr_q  <= addr_q + {{(ADDR_W-2){1'b0}}, idx_d};
            mem_wdata_q <= wdata_q[{idx_d, 3'b000} +: 8];
          end
        end
        RESP: begin
          state_q    <= IDLE;
          resp_err_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_byte_serial.sv
// Directed bench for lsu_byte_serial against a 64 KiB combinational-read Ram model.
module tb_lsu_byte_serial;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_width;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:65535];
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;

  int          n_checks;
  int          n_errors;
  int          lat;
  int          we_cnt;
  logic [31:0] got_rdata;
  logic        got_err;
  logic [31:0] addr_log [4];
  logic        saw_resp;

  lsu_byte_serial #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_width    (req_width),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[15:0]];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[15:0]] <= mem_wdata;
    if (pre_we) ram[pre_addr] <= pre_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // One request; afterwards lat = cycles from the accept cycle to resp_valid.
  task automatic do_req(input logic w, input logic [1:0] wd, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_width = wd; req_unsigned = u;
    req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0; req_write = ~w; req_width = 2'd3; req_unsigned = ~u;
    req_addr = 32'hCAFE_0000; req_wdata = 32'hFFFF_FFFF;
    lat = 1; we_cnt = 0;
    for (int i = 0; i < 4; i++) addr_log[i] = 32'h0BAD_0BAD;
    while (!resp_valid && lat < 20) begin
      if (lat <= 4) addr_log[lat-1] = mem_addr;
      if (mem_we) we_cnt++;
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
    if (mem_we) we_cnt++;
    got_rdata = resp_rdata;
    got_err   = resp_err;
    $display("txn write=%0d width=%0d uns=%0d addr=%h wdata=%h lat=%0d we_cycles=%0d rdata=%h err=%0d",
             w, wd, u, a, d, lat, we_cnt, got_rdata, got_err);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_width = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    pre_we = 1'b0; pre_addr = 16'd0; pre_data = 8'd0;

    poke(16'h0080, 8'h58); poke(16'h0081, 8'h00); poke(16'h0082, 8'h00); poke(16'h0083, 8'h00);
    poke(16'h0010, 8'hF0);
    poke(16'h0079, 8'hA5); poke(16'h007A, 8'hA5); poke(16'h007B, 8'hA5);
    poke(16'hFFFE, 8'h11); poke(16'hFFFF, 8'h22); poke(16'h0000, 8'h33); poke(16'h0001, 8'h44);
    poke(16'h0040, 8'h34); poke(16'h0041, 8'h92);
    for (int i = 0; i < 4; i++) poke(16'h0020 + 16'(i), 8'hA5);

    check("rst_ready",  req_ready,  32'd1);
    check("rst_rvalid", resp_valid, 32'd0);
    check("rst_err",    resp_err,   32'd0);
    check("rst_rdata",  resp_rdata, 32'd0);
    check("rst_we",     mem_we,     32'd0);
    check("rst_maddr",  mem_addr,   32'd0);
    check("rst_mwdata", mem_wdata,  32'd0);
    rst_n = 1'b1;

    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'd0);
    check("lw_lat",   lat,       32'd5);
    check("lw_rdata", got_rdata, 32'h0000_0058);
    check("lw_err",   got_err,   32'd0);
    check("lw_we",    we_cnt,    32'd0);

    do_req(1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'd0);
    check("lb_lat",   lat,       32'd2);
    check("lb_rdata", got_rdata, 32'hFFFF_FFF0);
    do_req(1'b0, 2'd0, 1'b1, 32'h0000_0010, 32'd0);
    check("lbu_lat",   lat,       32'd2);
    check("lbu_rdata", got_rdata, 32'h0000_00F0);

    do_req(1'b1, 2'd1, 1'b0, 32'h0000_0079, 32'hDEAD_BEEF);
    check("sh_lat",   lat,       32'd3);
    check("sh_we",    we_cnt,    32'd2);
    check("sh_rdata", got_rdata, 32'h0000_00F0);
    check("sh_m79",   ram[16'h0079], 32'h0000_00EF);
    check("sh_m7a",   ram[16'h007A], 32'h0000_00BE);
    check("sh_m7b",   ram[16'h007B], 32'h0000_00A5);

    do_req(1'b0, 2'd2, 1'b1, 32'hFFFF_FFFE, 32'd0);
    check("wrap_a0",    addr_log[0], 32'hFFFF_FFFE);
    check("wrap_a1",    addr_log[1], 32'hFFFF_FFFF);
    check("wrap_a2",    addr_log[2], 32'h0000_0000);
    check("wrap_a3",    addr_log[3], 32'h0000_0001);
    check("wrap_rdata", got_rdata,   32'h4433_2211);

    do_req(1'b0, 2'd1, 1'b0, 32'h0000_0040, 32'd0);
    check("lh_lat",   lat,       32'd3);
    check("lh_rdata", got_rdata, 32'hFFFF_9234);
    do_req(1'b0, 2'd1, 1'b1, 32'h0000_0040, 32'd0);
    check("lhu_rdata", got_rdata, 32'h0000_9234);

    // Reset lands on the edge that would start the third store byte.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_width = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0000_0020; req_wdata = 32'h0403_0201;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid_we1", mem_we, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", req_ready,  32'd1);
    check("rst_mid_we",    mem_we,     32'd0);
    check("rst_mid_rvld",  resp_valid, 32'd0);
    rst_n = 1'b1;
    saw_resp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    check("rst_mid_noresp", saw_resp, 32'd0);
    check("rst_mid_m20", ram[16'h0020], 32'h0000_0001);
    check("rst_mid_m21", ram[16'h0021], 32'h0000_0002);
    check("rst_mid_m22", ram[16'h0022], 32'h0000_00A5);
    check("rst_mid_m23", ram[16'h0023], 32'h0000_00A5);
    $display("txn write=1 width=2 addr=00000020 wdata=04030201 reset_mid_xfer resp_seen=%0d", saw_resp);

    do_req(1'b1, 2'd3, 1'b0, 32'h0000_0020, 32'h1111_1111);
    check("bad_lat", lat,     32'd1);
    check("bad_err", got_err, 32'd1);
    check("bad_we",  we_cnt,  32'd0);
    @(negedge clk);
    check("bad_ready_after", req_ready,  32'd1);
    check("bad_rvld_after",  resp_valid, 32'd0);
    check("bad_err_after",   resp_err,   32'd0);
    check("bad_m20", ram[16'h0020], 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
